// File: rtl/rgb_led_sequencer.sv
// RGB LED colour sequencer: steps RLED/GLED/BLED through the 8-colour cycle with
// run/pause, direction, programmable dwell, single-step and PWM brightness.
module rgb_led_sequencer #(
    parameter int DWELL_W = 24,
    parameter int PWM_W   = 8
) (
    input  logic               clk_2m,
    input  logic               combo_reset,
    input  logic               en,
    input  logic               dir_up,
    input  logic               step_req,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [PWM_W-1:0]   brightness,
    output logic [2:0]         color_idx,
    output logic               rled,
    output logic               gled,
    output logic               bled,
    output logic               wrap,
    output logic               running
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [2:0]         color_idx_q, color_idx_d;
    logic               rled_q, rled_d;
    logic               gled_q, gled_d;
    logic               bled_q, bled_d;
    logic               wrap_q, wrap_d;
    logic               running_q, running_d;

    logic [DWELL_W-1:0] dwell_lim_s;
    logic               adv_s;
    logic               ch_on_s;
    logic               led_en_s;

    function automatic logic [2:0] next_color(input logic [2:0] c, input logic up);
        if (up) begin
            next_color = c + 3'd1;
        end else begin
            next_color = c - 3'd1;
        end
    endfunction

    // State register and all output flops
    always_ff @(posedge clk_2m or posedge combo_reset) begin
        if (combo_reset) begin
            state_q     <= ST_IDLE;
            dwell_cnt_q <= {DWELL_W{1'b0}};
            pwm_cnt_q   <= {PWM_W{1'b0}};
            color_idx_q <= 3'd0;
            rled_q      <= 1'b0;
            gled_q      <= 1'b0;
            bled_q      <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            color_idx_q <= color_idx_d;
            rled_q      <= rled_d;
            gled_q      <= gled_d;
            bled_q      <= bled_d;
            wrap_q      <= wrap_d;
            running_q   <= running_d;
        end
    end

    // Next-state, dwell timing, colour advance and LED drive
    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        color_idx_d = color_idx_q;
        wrap_d      = 1'b0;
        adv_s       = 1'b0;
        pwm_cnt_d   = pwm_cnt_q + {{(PWM_W-1){1'b0}}, 1'b1};

        // A dwell of 0 behaves as 1, so the terminal count saturates at 0
        if (dwell_cycles == {DWELL_W{1'b0}}) begin
            dwell_lim_s = {DWELL_W{1'b0}};
        end else begin
            dwell_lim_s = dwell_cycles - {{(DWELL_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_RUN;
                    dwell_cnt_d = {DWELL_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_PAUSE;
                end else if (dwell_cnt_q >= dwell_lim_s) begin
                    adv_s       = 1'b1;
                    dwell_cnt_d = {DWELL_W{1'b0}};
                end else begin
                    dwell_cnt_d = dwell_cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PAUSE: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    adv_s = 1'b1;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                dwell_cnt_d = {DWELL_W{1'b0}};
            end
        endcase

        if (adv_s) begin
            color_idx_d = next_color(color_idx_q, dir_up);
            wrap_d      = (dir_up && (color_idx_q == 3'd7)) || (!dir_up && (color_idx_q == 3'd0));
        end else begin
            color_idx_d = color_idx_q;
        end

        ch_on_s   = (pwm_cnt_q < brightness) || (brightness == {PWM_W{1'b1}});
        led_en_s  = (state_q != ST_IDLE);
        rled_d    = color_idx_q[2] & ch_on_s & led_en_s;
        gled_d    = color_idx_q[1] & ch_on_s & led_en_s;
        bled_d    = color_idx_q[0] & ch_on_s & led_en_s;
        running_d = (state_d == ST_RUN);
    end

    assign color_idx = color_idx_q;
    assign rled      = rled_q;
    assign gled      = gled_q;
    assign bled      = bled_q;
    assign wrap      = wrap_q;
    assign running   = running_q;

endmodule

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
Controller that sequences the board RGB LED (RLED/GLED/BLED) through the 8-color cycle under explicit control: run/pause, direction, programmable dwell per color, single-step, and PWM brightness. It replaces direct LED drive from free-running counter bits. Runs on clk_2m, with the LED outputs going straight to the top-level LED pins.

Parameters:
DWELL_W, 24, width of dwell_cycles and the internal dwell counter
PWM_W, 8, width of brightness and the internal PWM counter

Ports:
clk_2m  input  1  2 MHz PLL output clock
combo_reset  input  1  asynchronous, active-high reset
en  input  1  level; 1 = run, 0 = pause
dir_up  input  1  1 = color index increments, 0 = decrements (DIP_SW[0])
step_req  input  1  single-cycle pulse; advances one color, honoured only in PAUSE
dwell_cycles  input  DWELL_W  clk_2m cycles per color; 0 treated as 1
brightness  input  PWM_W  PWM duty; 0 = off, all-ones = 100 %
color_idx  output  3  current color; bit2 = R, bit1 = G, bit0 = B
rled  output  1  red LED drive, registered
gled  output  1  green LED drive, registered
bled  output  1  blue LED drive, registered
wrap  output  1  one-cycle pulse when color_idx wraps (7->0 up, 0->7 down)
running  output  1  1 while FSM is in RUN

Behaviour:
- Reset: combo_reset asynchronous, active-high; clock clk_2m. All outputs 0, state IDLE, dwell_cnt = 0, pwm_cnt = 0, color_idx = 0.
- States: IDLE, RUN, PAUSE.
- IDLE: LEDs held off, counters frozen. en = 1 moves to RUN next cycle with dwell_cnt = 0. step_req is ignored.
- RUN: running = 1. dwell_cnt increments every cycle.
  - If dwell_cnt >= max(dwell_cycles,1) - 1, color advances and dwell_cnt clears. The >= compare means that lowering dwell_cycles below dwell_cnt advances on the next cycle.
  - en = 0 moves to PAUSE next cycle with no advance in that cycle.
- PAUSE: LEDs keep showing color_idx and dwell_cnt is frozen.
  - en = 1 returns to RUN and resumes from the frozen dwell_cnt.
  - step_req = 1 with en = 0 advances color_idx by one in the dir_up direction and leaves dwell_cnt unchanged.
  - If step_req and en = 1 occur in the same cycle, en wins and the step is dropped.
- Advance arithmetic: up gives color_idx + 1 mod 8, down gives color_idx - 1 mod 8.
  - wrap = 1 in the cycle color_idx takes its new value, only on 7->0 (up) or 0->7 (down). This applies to timed advances and steps alike.
  - A dir_up change takes effect at the next advance. There is no dwell restart.
- PWM: pwm_cnt is free-running from reset, modulo 2^PWM_W, in all states.
  - ch_on = (pwm_cnt < brightness) or (brightness == all-ones).
  - rled = color_idx[2] & ch_on & (state != IDLE); gled and bled are the same with bits 1 and 0.
  - Period is 256 cycles (128 us), with one cycle of latency from color_idx/pwm_cnt to the LED pins.
- Reset mid-operation returns immediately to the reset values above. There is no resume.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, en = 1, dir_up = 1, dwell_cycles = 4, brightness = 8'hFF → color_idx steps 0,1,…,7,0 every 4 cycles. wrap pulses once at 7->0. rled/gled/bled equal color_idx bits one cycle later.
- dir_up = 0, dwell_cycles = 0 → color_idx decrements every cycle: 0,7,6,…. wrap pulses on 0->7 only. running = 1 throughout.
- Run to color_idx = 3 with dwell_cnt = 2 of 5, drop en → PAUSE, outputs frozen at color 3. Three step_req pulses (dir_up = 1) → 4,5,6. Raise en → next advance after 3 more cycles (dwell resumed at 2).
- color_idx = 7, brightness = 64 → each LED high exactly 64 of every 256 cycles. brightness = 0 → LEDs always low. brightness = 8'hFF → always high.
- During RUN at dwell_cnt = 1000 with dwell_cycles = 2000, set dwell_cycles = 10 → advance on the next cycle, then every 10 cycles.
- Assert combo_reset mid-RUN (color 5) asynchronously → all outputs 0 immediately. After release with en = 1, the sequence restarts from color 0 and the LEDs stay off for the first cycle.
